mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mdu_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: latches MD operands, models multi-cycle
// latency with a down-counter, and writes HI/LO when the operation retires.
module mdu_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_d,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_md
);

    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 4;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [2:0]         r_op;
    logic [W-1:0]       r_hi;
    logic [W-1:0]       r_lo;

    logic               w_issue;
    logic               w_done;

    logic [2*W-1:0]     w_prod_s;
    logic [2*W-1:0]     w_prod_u;
    logic               w_signed_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [W-1:0]       w_abs_a;
    logic [W-1:0]       w_abs_b;
    logic [W-1:0]       w_quo_mag;
    logic [W-1:0]       w_rem_mag;
    logic [W-1:0]       w_res_hi;
    logic [W-1:0]       w_res_lo;
    logic               w_res_wr;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: MD ops 0-3 launch a run; the run retires when the counter reaches 1
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && (mdop[2] == 1'b0)) begin
                    w_issue     = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Divide on magnitudes, then restore signs; this also yields the
    // 0x80000000 / -1 overflow result (LO=0x80000000, HI=0) without a special case.
    always_comb begin
        w_prod_s     = {{W{r_a[W-1]}}, r_a} * {{W{r_b[W-1]}}, r_b};
        w_prod_u     = {W'(0), r_a} * {W'(0), r_b};
        w_signed_div = (r_op == OP_DIV);
        w_a_neg      = w_signed_div & r_a[W-1];
        w_b_neg      = w_signed_div & r_b[W-1];
        w_abs_a      = w_a_neg ? (W'(0) - r_a) : r_a;
        w_abs_b      = w_b_neg ? (W'(0) - r_b) : r_b;
        w_quo_mag    = W'(0);
        w_rem_mag    = W'(0);
        if (r_b != W'(0)) begin
            w_quo_mag = w_abs_a / w_abs_b;
            w_rem_mag = w_abs_a % w_abs_b;
        end
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        w_res_wr = 1'b0;
        case (r_op)
            OP_MULT: begin
                w_res_hi = w_prod_s[2*W-1:W];
                w_res_lo = w_prod_s[W-1:0];
                w_res_wr = 1'b1;
            end
            OP_MULTU: begin
                w_res_hi = w_prod_u[2*W-1:W];
                w_res_lo = w_prod_u[W-1:0];
                w_res_wr = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                w_res_lo = (w_a_neg ^ w_b_neg) ? (W'(0) - w_quo_mag) : w_quo_mag;
                w_res_hi = w_a_neg ? (W'(0) - w_rem_mag) : w_rem_mag;
                w_res_wr = (r_b != W'(0));
            end
            default: w_res_wr = 1'b0;
        endcase
    end

    // Operand latch, latency counter and HI/LO registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= CNT_W'(0);
            r_a   <= W'(0);
            r_b   <= W'(0);
            r_op  <= 3'd0;
            r_hi  <= W'(0);
            r_lo  <= W'(0);
        end else if (w_issue) begin
            r_a   <= a;
            r_b   <= b;
            r_op  <= mdop;
            r_cnt <= (mdop[1] == 1'b0) ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_done && w_res_wr) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end else if (start) begin
            if (mdop == OP_MTHI) begin
                r_hi <= a;
            end else if (mdop == OP_MTLO) begin
                r_lo <= a;
            end
        end
    end

    assign busy     = (r_state == RUN);
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign stall_md = md_use_d & (busy | (start & (mdop[2] == 1'b0)));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl with hand-computed HI/LO results.
module tb_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use_d;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall_md;

    int n_checks;
    int n_fail;

    mdu_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mdop     (mdop),
        .a        (a),
        .b        (b),
        .md_use_d (md_use_d),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .stall_md (stall_md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an op for one rising edge; returns at the negedge after that edge
    task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        start = 1'b1;
        mdop  = op;
        a     = va;
        b     = vb;
        @(negedge clk);
        start = 1'b0;
        mdop  = 3'd7;
    endtask

    // Counts negedge samples with busy high, bounded
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic check_run(input string name, input int lat,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        wait_idle(cyc);
        n_checks++;
        if (cyc !== lat) begin
            n_fail++;
            $display("FAIL %s busy_cycles got %0d expected %0d", name, cyc, lat);
        end
        n_checks++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            n_fail++;
            $display("FAIL %s hilo got %h_%h expected %h_%h", name, hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0; mdop = 3'd7; a = '0; b = '0; md_use_d = 1'b1;
        #12;
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || stall_md !== 1'b0) begin
            n_fail++;
            $display("FAIL reset got busy=%b hi=%h lo=%h stall=%b expected 0", busy, hi, lo, stall_md);
        end
        @(negedge clk);
        reset = 1'b1;
        md_use_d = 1'b0;
    endtask

    task automatic test_mult();
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        // Operands changed after issue must not affect the result
        a = 32'h1234_0000; b = 32'h7;
        n_checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL mult_no_bypass got %h_%h expected 00000000_00000000", hi, lo);
        end
        check_run("mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    endtask

    task automatic test_multu();
        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        check_run("multu", 5, 32'h0000_0001, 32'hFFFF_FFFE);
    endtask

    task automatic test_div();
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        check_run("div_neg", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(3'd2, 32'd7, 32'hFFFF_FFFE);
        check_run("div_negdivisor", 10, 32'h0000_0001, 32'hFFFF_FFFD);
        issue(3'd3, 32'd100, 32'd7);
        check_run("divu", 10, 32'h0000_0002, 32'h0000_000E);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check_run("div_overflow", 10, 32'h0000_0000, 32'h8000_0000);
    endtask

    task automatic test_div_zero();
        issue(3'd4, 32'hAAAA_5555, 32'd0);
        issue(3'd5, 32'h1111_2222, 32'd0);
        issue(3'd3, 32'd7, 32'd0);
        check_run("divu_zero", 10, 32'hAAAA_5555, 32'h1111_2222);
        issue(3'd2, 32'hFFFF_FFF0, 32'd0);
        check_run("div_zero", 10, 32'hAAAA_5555, 32'h1111_2222);
    endtask

    task automatic test_mtlo_noop();
        int cyc;
        issue(3'd5, 32'h1234_5678, 32'd0);
        wait_idle(cyc);
        n_checks++;
        if (lo !== 32'h1234_5678 || hi !== 32'hAAAA_5555 || cyc !== 0) begin
            n_fail++;
            $display("FAIL mtlo got lo=%h hi=%h busy_cycles=%0d expected 12345678 aaaa5555 0", lo, hi, cyc);
        end
        issue(3'd6, 32'h0BAD_0BAD, 32'd1);
        wait_idle(cyc);
        n_checks++;
        if (lo !== 32'h1234_5678 || hi !== 32'hAAAA_5555 || cyc !== 0) begin
            n_fail++;
            $display("FAIL noop got lo=%h hi=%h busy_cycles=%0d expected 12345678 aaaa5555 0", lo, hi, cyc);
        end
    endtask

    task automatic test_mthi_during_run();
        int cyc;
        issue(3'd1, 32'd1, 32'd1);
        issue(3'd4, 32'hDEAD_BEEF, 32'd0);
        n_checks++;
        if (hi !== 32'hAAAA_5555 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mthi_in_run got hi=%h busy=%b expected aaaa5555 1", hi, busy);
        end
        wait_idle(cyc);
        n_checks++;
        if (hi !== 32'h0 || lo !== 32'h1 || cyc !== 3) begin
            n_fail++;
            $display("FAIL mthi_in_run_result got %h_%h cyc=%0d expected 00000000_00000001 cyc=3", hi, lo, cyc);
        end
    endtask

    task automatic test_stall();
        int cyc;
        int bad;
        md_use_d = 1'b1;
        @(negedge clk);
        start = 1'b1; mdop = 3'd3; a = 32'd9; b = 32'd2;
        #1;
        n_checks++;
        if (stall_md !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_issue got %b expected 1", stall_md);
        end
        @(negedge clk);
        start = 1'b0; mdop = 3'd7;
        cyc = 0; bad = 0;
        while (busy && cyc < 40) begin
            if (stall_md !== 1'b1) bad++;
            cyc++;
            @(negedge clk);
        end
        n_checks++;
        if (bad !== 0 || cyc !== 10 || stall_md !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_busy got bad=%0d cyc=%0d stall_after=%b expected 0 10 0", bad, cyc, stall_md);
        end
        md_use_d = 1'b0;
        issue(3'd0, 32'd4, 32'd4);
        n_checks++;
        if (busy !== 1'b1 || stall_md !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_no_use got busy=%b stall=%b expected 1 0", busy, stall_md);
        end
        check_run("divu_stall_then_mult", 5, 32'h0, 32'h10);
    endtask

    task automatic test_reset_mid_run();
        issue(3'd2, 32'd100, 32'd3);
        // After issue edge N plus 7 more edges the counter holds 3
        repeat (7) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_run got busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_hold got busy=%b hi=%h lo=%h expected 0 0 0", busy, hi, lo);
        end
        reset = 1'b1;
        issue(3'd0, 32'd2, 32'd3);
        check_run("mult_after_reset", 5, 32'h0, 32'h6);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_zero();
        test_mtlo_noop();
        test_mthi_during_run();
        test_stall();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
